nonce_receiver: RTL
===================

NONCE_RECEIVER -- requirements
Module: nonce_receiver

Interface
REQ-001 Parameter: NONCE_W, 32, width of the serial nonce; this block supports only 32.
REQ-002 clk  in  1  single clock; all state updates on its rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 valid_i  in  1  registered valid from the nonce buffer's victory status interface.
REQ-005 success_i  in  1  registered success from the nonce buffer.
REQ-006 nonce_i  in  1  serial nonce bit from the buffer, LSB first.
REQ-007 error_i  in  1  buffer error flag; sticky on the buffer side.
REQ-008 readready  out  1  one-cycle request that starts the buffer's serial shift-out.
REQ-009 nonce_o  out  32  last fully assembled nonce.
REQ-010 nonce_valid_o  out  1  nonce_o holds an unacknowledged nonce.
REQ-011 nonce_ack_i  in  1  consumer accepts nonce_o when high with nonce_valid_o.
REQ-012 busy_o  out  1  high in REQ and SHIFT states.
REQ-013 err_o  out  1  sticky error.

Function
REQ-014 States: IDLE, REQ, SHIFT, HOLD.
REQ-015 win = valid_i && success_i, sampled at each rising edge.
REQ-016 In IDLE, win moves the FSM to REQ at the next edge; otherwise it stays in IDLE.
REQ-017 readready is high only in REQ, for exactly one cycle per transfer, and is never high in SHIFT.
REQ-018 In REQ, nonce_i is captured as bit 0; the FSM then moves to SHIFT with the bit counter at 1.
REQ-019 In SHIFT, nonce_i is captured as bit[count] each cycle and count increments; after capturing bit 31, nonce_o loads all 32 bits and the FSM enters HOLD.
REQ-020 Latency: a win sampled at edge t gives readready in cycle t+1, bits in cycles t+1..t+32, and nonce_valid_o high from cycle t+33.
REQ-021 nonce_o changes only on entry to HOLD; the assembly shift register is internal and separate.
REQ-022 In HOLD, nonce_valid_o = 1.
REQ-023 A HOLD cycle with nonce_ack_i = 1 leaves HOLD: to REQ if pending is set or win is high in that cycle, otherwise to IDLE.
REQ-024 A win during HOLD without ack sets the one-deep pending flag.
REQ-025 Leaving HOLD for REQ clears the pending flag.
REQ-026 nonce_ack_i is ignored outside HOLD.
REQ-027 Overflow is any of: a win during REQ or SHIFT (the buffer overwrites its nonce mid-transfer); a win during HOLD while pending is already set; a win during HOLD while pending is clear and nonce_ack_i is low is not overflow (it sets pending per REQ-024).
REQ-028 Overflow sets err_o and does not alter the FSM.
REQ-029 The transfer in progress completes normally, and its nonce is marked valid even though it may be corrupt.
REQ-030 error_i = 1 in any cycle sets err_o.
REQ-031 err_o remains set until reset.
REQ-032 nonce_o holds its value after ack until the next HOLD entry.

Reset
REQ-033 While rst is asserted: FSM = IDLE, count = 0, pending = 0, readready = 0, nonce_valid_o = 0, busy_o = 0, err_o = 0, nonce_o = 0.
REQ-034 Reset asserted mid-transfer aborts the transfer immediately; no partial nonce ever reaches nonce_o.
REQ-035 The first win after reset release is handled per REQ-016.

Structure
REQ-036 A shared package holds the FSM state enum type and the NONCE_W constant.
REQ-037 All flops use the team's existing reset/enable flip-flop primitives, with asynchronous reset.
REQ-038 One sub-module, nonce_sipo (32-bit LSB-first serial-in/parallel-out register with shift enable), is natural and is used for the assembly register.
REQ-039 Outputs readready, nonce_valid_o, busy_o and err_o are decoded from registered state only, with no input-to-output combinational path.

Verification
REQ-040 Single transfer: after reset, win at edge 10 with serial source 0xDEADBEEF -> readready high in cycle 11 only; nonce_o = 0xDEADBEEF with nonce_valid_o = 1 in cycle 43; err_o = 0.
REQ-041 Ack and back-to-back: in HOLD with value 0x00000001, ack and win in the same cycle -> next cycle is REQ, readready = 1, nonce_valid_o = 0, nonce_o still 0x00000001; second nonce 0x80000000 is delivered intact.
REQ-042 Pending: win during HOLD, ack 5 cycles later -> REQ on the cycle after ack; exactly one readready per win; err_o = 0.
REQ-043 Overflow: win in SHIFT at count = 17 -> err_o = 1 from the next cycle; transfer completes; nonce_valid_o asserts on schedule; err_o persists until rst.
REQ-044 Reset mid-op: rst asserted at count = 9 -> all outputs 0 immediately, with no clock edge required; after release, a new win 0x12345678 is delivered correctly.
REQ-045 error_i pulse: error_i high for one cycle in IDLE -> err_o = 1 and stays 1; FSM behaviour is unaffected.

Source files
------------

// File: rtl/nonce_receiver_pkg.sv
// Shared types and constants for the nonce receiver.
package nonce_receiver_pkg;

   // Serial nonce width; the bit counter below is sized for exactly this.
   localparam int NONCE_W = 32;
   localparam int CNT_W   = 5;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_REQ   = 2'd1,
      ST_SHIFT = 2'd2,
      ST_HOLD  = 2'd3
   } state_t;

endpackage

// File: rtl/nonce_receiver_sipo.sv
// 32-bit LSB-first serial-in/parallel-out assembly register.
// Bits enter at the MSB and move toward bit 0, so after W shifts the first
// bit received sits at bit 0. next_val exposes the value the register will
// hold after the current shift, letting the caller capture the complete word
// on the same edge the last bit arrives.
module nonce_sipo #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         shift_en,
   input  logic         bit_in,
   output logic [W-1:0] next_val
);

   logic [W-1:0] sr;
   logic         unused_lsb;

   assign next_val   = {bit_in, sr[W-1:1]};
   // The oldest bit falls off the end on every shift and is never read.
   assign unused_lsb = sr[0];

   // Shift one bit in per enabled cycle; reset clears any partial assembly.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         sr <= '0;
      else if (shift_en)
         sr <= next_val;
   end

endmodule

// File: rtl/nonce_receiver.sv
// Nonce receiver: on a buffer win, requests a serial shift-out, assembles
// the 32-bit nonce, and holds it until the consumer acknowledges.
// One further win may be queued while holding; anything beyond that, or a
// win while a transfer is in flight, is flagged on the sticky err_o.
module nonce_receiver #(
   parameter int NONCE_W = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               valid_i,
   input  logic               success_i,
   input  logic               nonce_i,
   input  logic               error_i,
   output logic               readready,
   output logic [NONCE_W-1:0] nonce_o,
   output logic               nonce_valid_o,
   input  logic               nonce_ack_i,
   output logic               busy_o,
   output logic               err_o
);

   import nonce_receiver_pkg::*;

   state_t             state, state_next;
   logic [CNT_W-1:0]   count, count_next;
   logic               pending, pending_next;
   logic               err_q;
   logic               win;
   logic               overflow;
   logic               shift_en;
   logic               nonce_load;
   logic [NONCE_W-1:0] assembled;

   assign win = valid_i && success_i;

   nonce_sipo #(.W(NONCE_W)) u_sipo (
      .clk      (clk),
      .rst      (rst),
      .shift_en (shift_en),
      .bit_in   (nonce_i),
      .next_val (assembled)
   );

   // State, bit counter and pending flag registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= ST_IDLE;
         count   <= '0;
         pending <= 1'b0;
      end else begin
         state   <= state_next;
         count   <= count_next;
         pending <= pending_next;
      end
   end

   // Output nonce changes only when a full word is complete (entry to HOLD).
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         nonce_o <= '0;
      else if (nonce_load)
         nonce_o <= assembled;
   end

   // Sticky error: buffer error or overflow, cleared only by reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         err_q <= 1'b0;
      else if (overflow || error_i)
         err_q <= 1'b1;
   end

   // Next-state, counter, pending and overflow decode.
   always_comb begin
      state_next   = state;
      count_next   = count;
      pending_next = pending;
      shift_en     = 1'b0;
      nonce_load   = 1'b0;
      overflow     = 1'b0;
      case (state)
         ST_IDLE: begin
            if (win)
               state_next = ST_REQ;
         end
         ST_REQ: begin
            // Bit 0 is already on the wire while readready is high.
            shift_en   = 1'b1;
            count_next = CNT_W'(1);
            state_next = ST_SHIFT;
            overflow   = win;
         end
         ST_SHIFT: begin
            shift_en = 1'b1;
            overflow = win;
            if (count == CNT_W'(NONCE_W - 1)) begin
               nonce_load = 1'b1;
               count_next = '0;
               state_next = ST_HOLD;
            end else begin
               count_next = count + CNT_W'(1);
            end
         end
         ST_HOLD: begin
            // A second queued win cannot be stored: the older one is lost.
            if (win && pending)
               overflow = 1'b1;
            if (nonce_ack_i) begin
               if (pending || win) begin
                  state_next   = ST_REQ;
                  pending_next = 1'b0;
               end else begin
                  state_next = ST_IDLE;
               end
            end else if (win) begin
               pending_next = 1'b1;
            end
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   // Handshake outputs come from registered state only.
   assign readready     = (state == ST_REQ);
   assign busy_o        = (state == ST_REQ) || (state == ST_SHIFT);
   assign nonce_valid_o = (state == ST_HOLD);
   assign err_o         = err_q;

endmodule
